// File: rtl/proc_phase_sequencer_pkg.sv
// Shared definitions for the processor phase sequencer: FSM state encodings,
// default phase placement and the decoded per-unit clock bundle.
package proc_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam int DEF_CYCLE_LEN = 4;
  localparam int DEF_IMEM_PH   = 0;
  localparam int DEF_DMEM_PH   = 2;
  localparam int DEF_RF_PH     = 3;

  typedef struct packed {
    logic imem_clk;
    logic dmem_clk;
    logic proc_clk;
    logic rf_clk;
    logic cycle_start;
    logic halted;
  } dec_t;

  function automatic int ph_w(input int cycle_len);
    return (cycle_len > 1) ? $clog2(cycle_len) : 1;
  endfunction

endpackage

// File: rtl/proc_phase_sequencer_if.sv
// Control inputs and derived clock/status outputs of the phase sequencer.
interface proc_phase_sequencer_if #(
  parameter int PH_W  = 2,
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             stall_req;
  logic             imem_clock;
  logic             dmem_clock;
  logic             processor_clock;
  logic             regfile_clock;
  logic [PH_W-1:0]  phase;
  logic             cycle_start;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run, step, stall_req,
    input  imem_clock, dmem_clock, processor_clock, regfile_clock,
    input  phase, cycle_start, halted, cycle_count
  );

  modport slave (
    input  run, step, stall_req,
    output imem_clock, dmem_clock, processor_clock, regfile_clock,
    output phase, cycle_start, halted, cycle_count
  );
endinterface

// File: rtl/proc_phase_sequencer_clk_phase_decode.sv
// Pure combinational map from (state, phase) to the unit clock pattern and
// status bits; the caller registers the result so outputs stay glitch-free.
module clk_phase_decode
  import proc_phase_sequencer_pkg::*;
#(
  parameter int CYCLE_LEN = DEF_CYCLE_LEN,
  parameter int IMEM_PH   = DEF_IMEM_PH,
  parameter int DMEM_PH   = DEF_DMEM_PH,
  parameter int RF_PH     = DEF_RF_PH,
  parameter int PH_W      = ph_w(CYCLE_LEN)
) (
  input  state_e          i_state,
  input  logic [PH_W-1:0] i_ph,
  output dec_t            o_dec
);

  logic w_run;
  int   w_ph;

  assign w_run = (i_state == ST_RUN);
  assign w_ph  = int'(i_ph);

  // Clocks only toggle in RUN; HALT and STALL park every unit clock low.
  assign o_dec.proc_clk    = w_run && (w_ph < CYCLE_LEN / 2);
  assign o_dec.imem_clk    = w_run && (w_ph == IMEM_PH);
  assign o_dec.dmem_clk    = w_run && (w_ph == DMEM_PH);
  assign o_dec.rf_clk      = w_run && (w_ph == RF_PH);
  assign o_dec.cycle_start = w_run && (w_ph == 0);
  assign o_dec.halted      = (i_state == ST_HALT);

endmodule

// File: rtl/proc_phase_sequencer.sv
// Divides the master clock into processor cycles and generates the per-unit
// clocks, with run/halt, single-step and stall control at cycle boundaries.
module proc_phase_sequencer
  import proc_phase_sequencer_pkg::*;
#(
  parameter int CYCLE_LEN = DEF_CYCLE_LEN,
  parameter int IMEM_PH   = DEF_IMEM_PH,
  parameter int DMEM_PH   = DEF_DMEM_PH,
  parameter int RF_PH     = DEF_RF_PH,
  parameter int CNT_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  proc_phase_sequencer_if.slave bus
);

  localparam int              PH_W = ph_w(CYCLE_LEN);
  localparam logic [PH_W-1:0] LAST = PH_W'(CYCLE_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  state_e           w_dec_state;
  logic [PH_W-1:0]  r_ph;
  logic [PH_W-1:0]  w_ph_nxt;
  logic [PH_W-1:0]  w_dec_ph;
  logic             r_step_pending;
  logic             w_pending_nxt;
  logic             w_last;
  logic             w_boundary;
  logic             w_go;
  logic [CNT_W-1:0] r_cnt;
  dec_t             w_dec;
  dec_t             r_dec;

  always_comb begin
    w_state_nxt   = r_state;
    w_ph_nxt      = r_ph;
    w_pending_nxt = r_step_pending;
    w_last        = (r_ph == LAST);
    w_boundary    = (r_state != ST_RUN) || w_last;
    w_go          = bus.run || r_step_pending || bus.step;

    if (bus.step && !bus.run) begin
      w_pending_nxt = 1'b1;
    end

    // Mid-cycle the inputs are ignored; decisions happen only at the boundary.
    if (w_boundary) begin
      if (bus.stall_req) begin
        w_state_nxt = ST_STALL;
        w_ph_nxt    = LAST;
      end else if (w_go) begin
        w_state_nxt   = ST_RUN;
        w_ph_nxt      = '0;
        w_pending_nxt = 1'b0;
      end else begin
        w_state_nxt = ST_HALT;
        w_ph_nxt    = LAST;
      end
    end else begin
      w_ph_nxt = r_ph + PH_W'(1);
    end
  end

  // Outputs are decoded from the post-edge state so they land with ph.
  assign w_dec_state = reset ? ST_HALT : w_state_nxt;
  assign w_dec_ph    = reset ? LAST    : w_ph_nxt;

  clk_phase_decode #(
    .CYCLE_LEN (CYCLE_LEN),
    .IMEM_PH   (IMEM_PH),
    .DMEM_PH   (DMEM_PH),
    .RF_PH     (RF_PH),
    .PH_W      (PH_W)
  ) u_decode (
    .i_state (w_dec_state),
    .i_ph    (w_dec_ph),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_HALT;
      r_ph           <= LAST;
      r_step_pending <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ph           <= w_ph_nxt;
      r_step_pending <= w_pending_nxt;
      if (r_state == ST_RUN && w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    r_dec <= w_dec;
  end

  assign bus.imem_clock      = r_dec.imem_clk;
  assign bus.dmem_clock      = r_dec.dmem_clk;
  assign bus.processor_clock = r_dec.proc_clk;
  assign bus.regfile_clock   = r_dec.rf_clk;
  assign bus.cycle_start     = r_dec.cycle_start;
  assign bus.halted          = r_dec.halted;
  assign bus.phase           = r_ph;
  assign bus.cycle_count     = r_cnt;

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Scoreboard bench for proc_phase_sequencer: directed ticks push expected
// output snapshots, a negedge monitor pops and compares them.
module tb_proc_phase_sequencer;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic run       = 1'b0;
  logic step      = 1'b0;
  logic stall_req = 1'b0;

  always #5 clock = ~clock;

  proc_phase_sequencer_if #(.PH_W(2), .CNT_W(32)) bus  ();
  proc_phase_sequencer_if #(.PH_W(2), .CNT_W(4))  bus4 ();

  assign bus.run        = run;
  assign bus.step       = step;
  assign bus.stall_req  = stall_req;
  assign bus4.run       = run;
  assign bus4.step      = step;
  assign bus4.stall_req = stall_req;

  proc_phase_sequencer #(
    .CYCLE_LEN(4), .IMEM_PH(0), .DMEM_PH(2), .RF_PH(3), .CNT_W(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  proc_phase_sequencer #(
    .CYCLE_LEN(4), .IMEM_PH(0), .DMEM_PH(2), .RF_PH(3), .CNT_W(4)
  ) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    int          tid;
    logic [1:0]  ph;
    logic        pc, im, dm, rf, cs, hl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tid     = 0;

  // Expected RUN pattern per phase for CYCLE_LEN=4, IMEM=0, DMEM=2, RF=3.
  localparam bit PC_T [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit IM_T [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  localparam bit DM_T [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit RF_T [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam bit CS_T [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  function automatic exp_t R(input int p, input int c);
    exp_t e;
    e.tid = tid; e.ph = 2'(p);
    e.pc = PC_T[p]; e.im = IM_T[p]; e.dm = DM_T[p]; e.rf = RF_T[p];
    e.cs = CS_T[p]; e.hl = 1'b0; e.cnt = 32'(c);
    return e;
  endfunction

  function automatic exp_t H(input int c);
    exp_t e;
    e.tid = tid; e.ph = 2'd3;
    e.pc = 1'b0; e.im = 1'b0; e.dm = 1'b0; e.rf = 1'b0;
    e.cs = 1'b0; e.hl = 1'b1; e.cnt = 32'(c);
    return e;
  endfunction

  function automatic exp_t S(input int c);
    exp_t e;
    e = H(c);
    e.hl = 1'b0;
    return e;
  endfunction

  task automatic tick(input exp_t e);
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [43:0] act;
    logic [43:0] req;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.phase, bus.processor_clock, bus.imem_clock, bus.dmem_clock,
             bus.regfile_clock, bus.cycle_start, bus.halted,
             bus.cycle_count, bus4.cycle_count};
      req = {e.ph, e.pc, e.im, e.dm, e.rf, e.cs, e.hl, e.cnt, e.cnt[3:0]};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL T%0d snapshot {ph,pc,im,dm,rf,cs,hl,cnt,cnt4}: got %h, want %h",
                 e.tid, act, req);
      end
    end
  end

  initial begin
    // T1: reset then free run; ten full cycles
    tid = 1; reset = 1'b1; run = 1'b0;
    tick(H(0)); tick(H(0));
    reset = 1'b0; run = 1'b1;
    for (int c = 0; c < 10; c++)
      for (int p = 0; p < 4; p++) tick(R(p, c));
    tick(R(0, 10));

    // T5: reset mid-cycle at ph=2 aborts without counting
    tid = 5;
    tick(R(1, 10)); tick(R(2, 10));
    reset = 1'b1;
    tick(H(0));
    reset = 1'b0; run = 1'b0;
    tick(H(0));

    // T2: single steps
    tid = 2;
    step = 1'b1; tick(R(0, 0)); step = 1'b0;
    tick(R(1, 0)); tick(R(2, 0)); tick(R(3, 0));
    tick(H(1)); tick(H(1));
    step = 1'b1; tick(R(0, 1)); step = 1'b0;
    tick(R(1, 1)); tick(R(2, 1)); tick(R(3, 1));
    tick(H(2));

    // T3: stall raised at ph=1 for six ticks
    tid = 3; run = 1'b1;
    tick(R(0, 2)); tick(R(1, 2));
    stall_req = 1'b1;
    tick(R(2, 2)); tick(R(3, 2));
    tick(S(3)); tick(S(3)); tick(S(3)); tick(S(3));
    stall_req = 1'b0;
    tick(R(0, 3)); tick(R(1, 3)); tick(R(2, 3)); tick(R(3, 3));
    tick(R(0, 4));

    // T4: step during stall is held and launches once after release
    tid = 4; run = 1'b0;
    tick(R(1, 4)); tick(R(2, 4)); tick(R(3, 4)); tick(H(5));
    stall_req = 1'b1; step = 1'b1;
    tick(S(5));
    step = 1'b0;
    tick(S(5)); tick(S(5));
    stall_req = 1'b0;
    tick(R(0, 5)); tick(R(1, 5)); tick(R(2, 5)); tick(R(3, 5));
    tick(H(6)); tick(H(6));

    // T7: step while running is ignored
    tid = 7; run = 1'b1;
    tick(R(0, 6));
    step = 1'b1; tick(R(1, 6)); step = 1'b0;
    run = 1'b0;
    tick(R(2, 6)); tick(R(3, 6)); tick(H(7)); tick(H(7));

    // T6: run past 16 cycles; the 4-bit counter wraps to 0
    tid = 6; run = 1'b1;
    for (int c = 7; c <= 16; c++)
      for (int p = 0; p < 4; p++) tick(R(p, c));
    run = 1'b0;
    tick(H(17));

    repeat (2) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_phase_sequencer.md
Name: proc_phase_sequencer

Overview:
- Derives the four per-unit clocks (imem_clock, dmem_clock, processor_clock, regfile_clock) from the single master clock.
- Divides the master clock into processor cycles of CYCLE_LEN master ticks and places one pulse per unit at a fixed phase.
- Adds run/halt, single-step and stall control so multicycle memory or debug operations can freeze the processor cleanly.
- Sits at the top of skeleton; it replaces ad-hoc clock inversion/division and feeds every clocked element.

Parameters:
CYCLE_LEN, 4, master ticks per processor cycle; must be even and >= 4
IMEM_PH, 0, phase at which imem_clock is high
DMEM_PH, 2, phase at which dmem_clock is high
RF_PH, 3, phase at which regfile_clock is high
CNT_W, 32, width of cycle_count

Ports:
clock  in  1  master clock; all flops on posedge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = free-running processor cycles
step  in  1  one-tick pulse; requests exactly one processor cycle while run=0
stall_req  in  1  level; hold processor at the end-of-cycle boundary
imem_clock  out  1  derived clock, registered
dmem_clock  out  1  derived clock, registered
processor_clock  out  1  derived clock, registered
regfile_clock  out  1  derived clock, registered
phase  out  clog2(CYCLE_LEN)  current phase counter ph
cycle_start  out  1  high while ph==0 in RUN
halted  out  1  high in HALT
cycle_count  out  CNT_W  completed processor cycles, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, named `reset`.
- States: HALT, RUN, STALL. The encodings are fixed.
- ph register:
  - Counts 0..CYCLE_LEN-1 in RUN.
  - Holds CYCLE_LEN-1 (LAST) in HALT and STALL.
- Output decode:
  - All four clocks, cycle_start and halted are flops loaded from decode(next state, next ph) on the same edge as ph.
  - No combinational path exists from state to outputs, so outputs are glitch-free.
- Decode in RUN:
  - processor_clock = (ph < CYCLE_LEN/2).
  - imem_clock = (ph==IMEM_PH).
  - dmem_clock = (ph==DMEM_PH).
  - regfile_clock = (ph==RF_PH).
- Decode in HALT/STALL: all four clocks are 0.
- Reset (edge with reset=1, any state, any ph):
  - state=HALT, ph=LAST, all clocks 0, cycle_start=0, halted=1.
  - cycle_count=0, step_pending=0.
  - Reset mid-cycle aborts the cycle immediately; that cycle is not counted.
- step handling:
  - A step pulse sets step_pending whenever run=0.
  - step is ignored while run=1.
  - step_pending clears when it launches a cycle.
- Boundary decision, evaluated at an edge in RUN with ph==LAST, at every edge in STALL, and at every edge in HALT. Priority:
  1. stall_req=1 -> STALL, ph=LAST.
  2. run=1 or step_pending=1 (or step=1 this edge) -> RUN, ph=0.
  3. Otherwise -> HALT, ph=LAST.
- RUN with ph!=LAST: ph increments; run, step and stall_req are ignored mid-cycle.
- cycle_count increments by 1 on each edge where state==RUN and ph==LAST, regardless of next state.
- Simultaneous stall_req and step: stall wins; step_pending stays set and launches the cycle after the stall clears.
- Latency: from HALT with run=1, processor_clock rises one edge later.

Decomposition:
- Shared package/header proc_clk_defs:
  - state encodings (HALT=2'd0, RUN=2'd1, STALL=2'd2)
  - default phase constants
  - PH_W function/localparam
- One natural sub-module: clk_phase_decode, purely combinational; maps (state, ph) to the four clock bits plus cycle_start and halted, and feeds the output flops.
- The FSM and counters stay in proc_phase_sequencer.

Test Plan:
1. Reset 2 ticks, run=1 -> ticks after release show:
   - ph 0,1,2,3,0
   - processor_clock 1,1,0,0,1
   - imem 1,0,0,0
   - dmem 0,0,1,0
   - regfile 0,0,0,1
   - cycle_count=1 after 4th tick, 10 after 40 ticks.
2. run=0 after reset, step pulse once -> exactly one 4-tick cycle, then halted=1, cycle_count=1; a second step gives cycle_count=2.
3. run=1, stall_req high during ph=1 for 6 ticks:
   - cycle finishes (ph 2,3), then STALL with all clocks 0 for the remaining stall ticks.
   - Resumes at ph=0 the tick after stall_req drops.
   - cycle_count unchanged during the stall.
4. run=0 and stall_req=1 with a step pulse -> no cycle while stalled; one cycle runs after stall_req falls; step_pending then clears.
5. reset asserted at ph=2 in RUN -> next tick ph=3 (LAST), halted=1, clocks 0, cycle_count=0.
6. Wrap: CNT_W=4, run 16 cycles -> cycle_count returns to 0.
